// File: rtl/c499_key_loader_if.sv
// c499_key_loader_if
// Groups the serial key-load handshake and the committed key outputs of the
// c499 key loader into one bundle.
//   master : key source (drives key_sdi/key_sen/key_commit/key_abort,
//            observes the key and status outputs)
//   slave  : the loader itself
// KEY_P_W / KEY_X_W must match the parameters of the attached loader.
interface c499_key_loader_if #(
  parameter int KEY_P_W = 4,
  parameter int KEY_X_W = 39
);
  logic               key_sdi;
  logic               key_sen;
  logic               key_commit;
  logic               key_abort;
  logic [KEY_P_W-1:0] key_p;
  logic [KEY_X_W-1:0] key_x;
  logic               key_valid;
  logic               key_err;
  logic               key_busy;
  logic               key_locked;

  modport master (
    output key_sdi, key_sen, key_commit, key_abort,
    input  key_p, key_x, key_valid, key_err, key_busy, key_locked
  );

  modport slave (
    input  key_sdi, key_sen, key_commit, key_abort,
    output key_p, key_x, key_valid, key_err, key_busy, key_locked
  );
endinterface

// File: rtl/c499_key_loader.sv
// c499_key_loader
// Serially loads the locking key of a locked c499 core. A stream of
// N = KEY_P_W + KEY_X_W + 1 bits is shifted in first-bit-first: the first
// KEY_P_W bits form key_p, the next KEY_X_W bits form key_x and the last bit
// makes the overall parity even. A commit with exactly N bits and even parity
// loads the key; anything else lands in ERROR until aborted.
// Ports:
//   clk    : rising-edge clock for all state
//   rst_n  : asynchronous active-low reset
//   bus    : c499_key_loader_if.slave
//            key_sdi/key_sen   serial data / shift enable
//            key_commit        check and apply the shifted stream
//            key_abort         drop the partial stream, back to IDLE
//            key_p/key_x       registered committed key
//            key_valid         a committed key is present
//            key_err/key_busy/key_locked  ERROR / SHIFT / LOCKED state flags
module c499_key_loader #(
  parameter int KEY_P_W   = 4,
  parameter int KEY_X_W   = 39,
  parameter int LOCK_ONCE = 1
) (
  input logic                clk,
  input logic                rst_n,
  c499_key_loader_if.slave   bus
);
  localparam int N     = KEY_P_W + KEY_X_W + 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [N-1:0]       shadow_reg, shadow_next;
  logic [KEY_P_W-1:0] key_p_reg;
  logic [KEY_X_W-1:0] key_x_reg;
  logic               key_valid_reg;

  logic shift_en;
  logic shadow_clr;
  logic load_key;

  // Control: abort beats commit, commit beats shift (a shift bit presented
  // together with a commit is dropped).
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_en   = 1'b0;
    shadow_clr = 1'b0;
    load_key   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.key_abort) begin
          cnt_next   = '0;
          shadow_clr = 1'b1;
        end else if (bus.key_commit) begin
          if (cnt_reg == '0) state_next = ST_ERROR;
        end else if (bus.key_sen) begin
          shift_en   = 1'b1;
          cnt_next   = CNT_W'(1);
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.key_abort) begin
          cnt_next   = '0;
          shadow_clr = 1'b1;
          state_next = ST_IDLE;
        end else if (bus.key_commit) begin
          // Even parity over the whole stream, parity bit included.
          if (cnt_reg == CNT_FULL && !(^shadow_reg)) begin
            load_key   = 1'b1;
            cnt_next   = '0;
            state_next = (LOCK_ONCE != 0) ? ST_LOCKED : ST_IDLE;
          end else begin
            state_next = ST_ERROR;
          end
        end else if (bus.key_sen) begin
          if (cnt_reg == CNT_FULL) begin
            state_next = ST_ERROR;
          end else begin
            shift_en = 1'b1;
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_ERROR: begin
        if (bus.key_abort) begin
          cnt_next   = '0;
          shadow_clr = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_LOCKED: ;
      default: state_next = ST_IDLE;
    endcase
  end

  // Each shadow bit captures key_sdi only when the counter points at it.
  // In IDLE the counter is 0, so the first bit of a stream lands in bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_shadow
      always_comb begin
        shadow_next[gi] = shadow_reg[gi];
        if (shadow_clr)
          shadow_next[gi] = 1'b0;
        else if (shift_en && cnt_reg == CNT_W'(gi))
          shadow_next[gi] = bus.key_sdi;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      shadow_reg    <= '0;
      key_p_reg     <= '0;
      key_x_reg     <= '0;
      key_valid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shadow_reg <= shadow_next;
      if (load_key) begin
        key_p_reg     <= shadow_reg[KEY_P_W-1:0];
        key_x_reg     <= shadow_reg[KEY_P_W +: KEY_X_W];
        key_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.key_p      = key_p_reg;
  assign bus.key_x      = key_x_reg;
  assign bus.key_valid  = key_valid_reg;
  // Status flags are pure decodes of the state register.
  assign bus.key_err    = (state_reg == ST_ERROR);
  assign bus.key_busy   = (state_reg == ST_SHIFT);
  assign bus.key_locked = (state_reg == ST_LOCKED);
endmodule

// File: tb/tb_c499_key_loader.sv
// tb_c499_key_loader
// Drives directed key-load scenarios and randomized streams into
// c499_key_loader and compares every output each cycle against a
// queue-based reference of the loader's rules.
module tb_c499_key_loader;
  localparam int P = 4;
  localparam int X = 39;
  localparam int N = P + X + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  c499_key_loader_if #(.KEY_P_W(P), .KEY_X_W(X)) bus ();

  c499_key_loader #(.KEY_P_W(P), .KEY_X_W(X), .LOCK_ONCE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: the bits received so far, the committed key and flags.
  bit           q[$];
  logic [P-1:0] m_p;
  logic [X-1:0] m_x;
  bit           m_valid, m_err, m_locked;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_p = '0;
    m_x = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_locked = 1'b0;
  endfunction

  // One clock edge of the loader's rules, at the level of "stream so far".
  function automatic void model_step(input bit sdi, input bit sen, input bit commit, input bit abort);
    bit par;
    if (m_locked) return;
    if (abort) begin
      q.delete();
      m_err = 1'b0;
      return;
    end
    if (m_err) return;
    if (commit) begin
      par = 1'b0;
      foreach (q[i]) par ^= q[i];
      if (q.size() == N && par == 1'b0) begin
        for (int i = 0; i < P; i++) m_p[i] = q[i];
        for (int i = 0; i < X; i++) m_x[i] = q[P + i];
        m_valid = 1'b1;
        m_locked = 1'b1;
        q.delete();
      end else begin
        m_err = 1'b1;
      end
      return;
    end
    if (sen) begin
      if (q.size() == N) m_err = 1'b1;
      else q.push_back(sdi);
    end
  endfunction

  task automatic compare_all(input string tag);
    bit m_busy;
    m_busy = (q.size() > 0) && !m_err && !m_locked;
    check({tag, "_p"},      64'(bus.key_p),      64'(m_p));
    check({tag, "_x"},      64'(bus.key_x),      64'(m_x));
    check({tag, "_valid"},  64'(bus.key_valid),  64'(m_valid));
    check({tag, "_err"},    64'(bus.key_err),    64'(m_err));
    check({tag, "_busy"},   64'(bus.key_busy),   64'(m_busy));
    check({tag, "_locked"}, 64'(bus.key_locked), 64'(m_locked));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are compared
  // at the same point after the following edge.
  task automatic tick(input bit sdi, input bit sen, input bit commit, input bit abort, input string tag);
    bus.key_sdi    = sdi;
    bus.key_sen    = sen;
    bus.key_commit = commit;
    bus.key_abort  = abort;
    model_step(sdi, sen, commit, abort);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #2;
    compare_all(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_stream(input logic [N-1:0] s, input string tag);
    for (int i = 0; i < N; i++) tick(s[i], 1'b1, 1'b0, 1'b0, tag);
  endtask

  function automatic logic [N-1:0] mk_stream(input logic [P-1:0] p, input logic [X-1:0] x, input bit bad_par);
    bit par;
    par = (^{x, p}) ^ bad_par;
    return {par, x, p};
  endfunction

  task automatic commit_and_log(input string tag);
    tick(1'b0, 1'b0, 1'b1, 1'b0, tag);
    $display("commit %s: p=%h x=%h valid=%0d err=%0d locked=%0d",
             tag, bus.key_p, bus.key_x, bus.key_valid, bus.key_err, bus.key_locked);
  endtask

  logic [N-1:0] s;
  logic [P-1:0] rp;
  logic [X-1:0] rx;

  initial begin
    bus.key_sdi = 1'b0;
    bus.key_sen = 1'b0;
    bus.key_commit = 1'b0;
    bus.key_abort = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");

    // All-zero key.
    send_stream('0, "zeros");
    commit_and_log("zeros");
    check("zeros_locked_const", 64'(bus.key_locked), 64'd1);

    // p=1, x=1 with correct parity, then a locked-out second stream.
    do_reset("reset2");
    send_stream(mk_stream(4'h1, 39'h1, 1'b0), "p1x1");
    commit_and_log("p1x1");
    check("p1x1_p_const", 64'(bus.key_p), 64'h1);
    check("p1x1_x_const", 64'(bus.key_x), 64'h1);
    send_stream({N{1'b1}}, "locked_ones");
    tick(1'b1, 1'b1, 1'b1, 1'b1, "locked_all");
    commit_and_log("locked_ones");
    check("locked_hold_p", 64'(bus.key_p), 64'h1);
    do_reset("reset_from_locked");

    // Bad parity, then abort.
    send_stream(mk_stream(4'h1, 39'h1, 1'b1), "badpar");
    commit_and_log("badpar");
    check("badpar_err_const", 64'(bus.key_err), 64'd1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, "err_ignore_sen");
    tick(1'b0, 1'b0, 1'b0, 1'b1, "abort");
    check("abort_err_const", 64'(bus.key_err), 64'd0);

    // Short commit, commit from IDLE, then overflow.
    for (int i = 0; i < 20; i++) tick(1'($urandom), 1'b1, 1'b0, 1'b0, "short");
    commit_and_log("short");
    tick(1'b0, 1'b0, 1'b0, 1'b1, "abort2");
    commit_and_log("idle_commit");
    tick(1'b0, 1'b0, 1'b0, 1'b1, "abort3");
    for (int i = 0; i < N + 1; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, "overflow");
    check("overflow_err_const", 64'(bus.key_err), 64'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, "abort4");

    // Reset mid-stream, then a clean full stream.
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, "partial");
    do_reset("reset_mid");
    s = mk_stream(4'hA, 39'h5A5A5A5A5A, 1'b0);
    send_stream(s, "after_reset");
    commit_and_log("after_reset");

    // Randomized episodes with gaps, aborts, overflow and shift+commit.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset("rnd_reset");
      rp = P'($urandom);
      rx = {7'($urandom), 32'($urandom)};
      s = mk_stream(rp, rx, ($urandom_range(0, 4) == 0));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) tick(1'($urandom), 1'b0, 1'b0, 1'b0, "rnd_gap");
        if ($urandom_range(0, 79) == 0) tick(1'b0, 1'b0, 1'($urandom), 1'b1, "rnd_abort");
        tick(s[i], 1'b1, 1'b0, 1'b0, "rnd_shift");
      end
      if ($urandom_range(0, 5) == 0) tick(1'($urandom), 1'b1, 1'b0, 1'b0, "rnd_extra");
      bus.key_sen = 1'b0;
      tick(1'($urandom), ($urandom_range(0, 2) == 0), 1'b1, 1'b0, "rnd_commit");
      $display("commit rnd%0d: p=%h x=%h valid=%0d err=%0d locked=%0d",
               ep, bus.key_p, bus.key_x, bus.key_valid, bus.key_err, bus.key_locked);
      for (int k = 0; k < 4; k++)
        tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rnd_after");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/c499_key_loader.md
C499_KEY_LOADER -- requirements
Module: c499_key_loader

Interface
REQ-001 Parameter KEY_P_W, default 4, width of the mux-select key bus (p1..p4 of the locked c499 core).
REQ-002 Parameter KEY_X_W, default 39, width of the XOR key bus (X_1..X_39 of the locked c499 core).
REQ-003 Parameter LOCK_ONCE, default 1; when 1, the first good commit makes the key permanent until reset.
REQ-004 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 key_sdi  input  1  serial key data, sampled when key_sen=1.
REQ-008 key_sen  input  1  shift enable, one stream bit per cycle.
REQ-009 key_commit  input  1  request to check and apply the shifted stream.
REQ-010 key_abort  input  1  discard the partial stream and return to IDLE.
REQ-011 key_p  output  KEY_P_W  registered mux key; bit i drives p(i+1).
REQ-012 key_x  output  KEY_X_W  registered XOR key; bit i drives X_(i+1).
REQ-013 key_valid  output  1  high once key_p/key_x hold a committed key.
REQ-014 key_err  output  1  high while in ERROR.
REQ-015 key_busy  output  1  high while in SHIFT.
REQ-016 key_locked  output  1  high while in LOCKED.

Function
REQ-017 The stream SHALL be N = KEY_P_W+KEY_X_W+1 bits (44 at default), sent first-bit-first: stream bits 0..KEY_P_W-1 go to key_p[0..], the next KEY_X_W bits go to key_x[0..], and the last bit is parity.
REQ-018 Parity SHALL be even: the XOR of all N bits must be 0.
REQ-019 A shadow register and a bit counter cnt (0..N) SHALL accumulate the stream; key_p/key_x SHALL change only on a good commit.
REQ-020 The FSM SHALL have the states IDLE, SHIFT, ERROR and LOCKED.
REQ-021 IDLE: key_sen=1 -> store bit at shadow[0], set cnt=1, go to SHIFT; key_commit=1 with cnt=0 -> go to ERROR.
REQ-022 SHIFT: key_sen=1 with cnt<N -> store bit at shadow[cnt], increment cnt.
REQ-023 SHIFT: key_sen=1 with cnt=N -> overflow -> go to ERROR.
REQ-024 SHIFT: key_commit=1 with cnt=N and even parity -> load key_p/key_x from shadow and set key_valid=1 on the same edge (outputs visible the cycle after commit is sampled).
REQ-025 After a good commit: go to LOCKED if LOCK_ONCE=1, otherwise go to IDLE with cnt=0.
REQ-026 SHIFT: key_commit=1 with cnt!=N or odd parity -> go to ERROR; key_p, key_x and key_valid stay unchanged.
REQ-027 key_commit and key_sen in the same cycle: the commit SHALL take priority and the shift bit SHALL be discarded.
REQ-028 key_abort in IDLE, SHIFT or ERROR SHALL clear cnt and the shadow and go to IDLE; key_abort SHALL take priority over commit and shift; committed outputs stay unchanged.
REQ-029 ERROR SHALL ignore key_sen and key_commit and leave only on key_abort or reset.
REQ-030 LOCKED SHALL ignore key_sen, key_commit and key_abort; key_p/key_x SHALL hold until reset.
REQ-031 key_err, key_busy and key_locked SHALL be decoded from registered state, with no combinational path from inputs.

Reset
REQ-032 rst_n=0 SHALL immediately set state=IDLE, cnt=0, shadow=0, key_p=0, key_x=0, and key_valid, key_err, key_busy and key_locked to 0, including from LOCKED or mid-stream.
REQ-033 After rst_n deasserts, the first key_sen edge SHALL be treated as stream bit 0.

Verification
REQ-034 Shift 44 zeros, then commit -> next cycle key_p=0, key_x=0, key_valid=1, key_locked=1, key_err=0.
REQ-035 Stream with bit0=1, bit4=1, other bits 0, parity 0, then commit -> key_p=4'h1, key_x=39'h1, key_valid=1.
REQ-036 Same stream with parity bit 1 -> key_err=1, key_valid=0, key_p=0; then key_abort -> IDLE, key_err=0.
REQ-037 Commit after 20 bits -> ERROR; separately, 45 consecutive shifts -> ERROR on the 45th edge.
REQ-038 In LOCKED with key_p=4'h1, a second full stream of ones (parity 0) plus commit -> key_p stays 4'h1; rst_n pulse -> all outputs 0.
REQ-039 rst_n asserted after 30 bits, then a full stream of 44 bits -> the key loads correctly with no leftover bits.
